sram_arbiter: RTL and testbench

Sequences ownership of the single-port 64 KiB SRAM (`sram64k`) between its three masters: the SPI flash loader during boot, the 6502 bus during normal running, and the diagnostics SPI slave while the CPU is halted. It generates the CPU `rdy` / halt handshake so that ownership changes only on a safe 6502 cycle boundary. It replaces the ad-hoc `read_complete` / `halt` muxing in the top level.

---
 rtl/sram_arb_pkg.sv | 33 +++
 rtl/sram_arbiter_phi2_sync.sv | 34 +++
 rtl/sram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM ownership arbiter
package sram_arb_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_RUN,
    ST_DRAIN,
    ST_HALTED,
    ST_RESUME
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FLASH,
    OWN_CPU,
    OWN_DIAG
  } owner_e;

  localparam int PAGE_SHIFT = 12;
  localparam int WP_COUNT_W = 8;

  // DRAIN keeps the CPU as owner so an in-flight 6502 cycle can finish.
  function automatic owner_e owner_of(input arb_state_e s);
    case (s)
      ST_BOOT:   return OWN_FLASH;
      ST_RUN:    return OWN_CPU;
      ST_DRAIN:  return OWN_CPU;
      ST_HALTED: return OWN_DIAG;
      default:   return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sram_arbiter_phi2_sync.sv
// rtl/sram_arbiter_phi2_sync.sv - 2-flop sync of phi2/rwbar with registered phi2 falling-edge pulse
module phi2_sync (
  input  logic clk,
  input  logic reset,
  input  logic phi2_i,
  input  logic rwbar_i,
  output logic phi2_fall_o,
  output logic rwbar_sync_o
);

  logic [2:0] phi2_q;
  logic [1:0] rwbar_q;
  logic       fall_q;
  logic       rw_q;

  // phi2_q[1] is the synchronized level; phi2_q[2] is its previous value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phi2_q  <= '0;
      rwbar_q <= '0;
      fall_q  <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      phi2_q  <= {phi2_q[1:0], phi2_i};
      rwbar_q <= {rwbar_q[0], rwbar_i};
      fall_q  <= phi2_q[2] & ~phi2_q[1];
      rw_q    <= rwbar_q[1];
    end
  end

  assign phi2_fall_o  = fall_q;
  assign rwbar_sync_o = rw_q;

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - SRAM ownership arbiter (flash/CPU/diag) with 6502 RDY handshake
// Optional CPU page write protection: SRAM_ARB_WRITE_PROTECT_EN
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int TO_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boot_done,
  input  logic [ADDR_W-1:0] flash_addr,
  input  logic [DATA_W-1:0] flash_wdata,
  input  logic              flash_cs,
  input  logic              flash_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic              phi2,
  input  logic              rwbar,
  input  logic              diag_halt_req,
  input  logic [ADDR_W-1:0] diag_addr,
  input  logic [DATA_W-1:0] diag_wdata,
  input  logic              diag_cs,
  input  logic              diag_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              cpu_rdy,
  output logic              diag_halted,
  output logic              bus_drive_en,
  output logic              drain_timeout
`ifdef SRAM_ARB_WRITE_PROTECT_EN
  ,input  logic [15:0]           wp_mask
  ,output logic [WP_COUNT_W-1:0] wp_count
`endif
);

  localparam logic [TO_W-1:0] TO_MAX = '1;

  arb_state_e      state_q, state_d;
  logic [TO_W-1:0] cnt_q;
  logic            cpu_rdy_q, halted_q, drive_q;
  logic            timeout_hit;
  logic            phi2_fall, rwbar_sync;
  owner_e          owner;
  logic            wp_block;

  phi2_sync u_sync (
    .clk          (clk),
    .reset        (reset),
    .phi2_i       (phi2),
    .rwbar_i      (rwbar),
    .phi2_fall_o  (phi2_fall),
    .rwbar_sync_o (rwbar_sync)
  );

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    if (state_q != ST_BOOT && !boot_done) begin
      state_d = ST_BOOT;
    end else begin
      case (state_q)
        ST_BOOT:   if (boot_done) state_d = ST_RUN;
        ST_RUN:    if (diag_halt_req) state_d = ST_DRAIN;
        ST_DRAIN: begin
          // Only a read cycle is a safe stop point: the 6502 ignores RDY on writes.
          if (!diag_halt_req)               state_d = ST_RUN;
          else if (phi2_fall && rwbar_sync) state_d = ST_HALTED;
          else if (cnt_q == TO_MAX) begin
            state_d     = ST_HALTED;
            timeout_hit = 1'b1;
          end
        end
        ST_HALTED: if (!diag_halt_req) state_d = ST_RESUME;
        ST_RESUME: state_d = ST_RUN;
        default:   state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      cnt_q     <= '0;
      cpu_rdy_q <= 1'b0;
      halted_q  <= 1'b0;
      drive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (state_q != ST_DRAIN)  cnt_q <= '0;
      else if (cnt_q != TO_MAX) cnt_q <= cnt_q + 1'b1;
      cpu_rdy_q <= (state_d == ST_RUN);
      halted_q  <= (state_d == ST_HALTED);
      drive_q   <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end
  end

  assign owner         = owner_of(state_q);
  assign cpu_rdy       = cpu_rdy_q;
  assign diag_halted   = halted_q;
  assign bus_drive_en  = drive_q;
  assign drain_timeout = timeout_hit;

`ifdef SRAM_ARB_WRITE_PROTECT_EN
  logic [WP_COUNT_W-1:0] wp_count_q;
  logic                  wp_seen_q;
  logic                  wp_hit;

  assign wp_block = wp_mask[cpu_addr[PAGE_SHIFT+3:PAGE_SHIFT]];
  assign wp_hit   = (owner == OWN_CPU) && cpu_cs && cpu_we && wp_block;

  // wp_seen_q limits counting to one suppressed write per cpu_cs assertion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_count_q <= '0;
      wp_seen_q  <= 1'b0;
    end else if (!cpu_cs) begin
      wp_seen_q  <= 1'b0;
    end else if (wp_hit) begin
      wp_seen_q  <= 1'b1;
      if (!wp_seen_q && wp_count_q != '1) wp_count_q <= wp_count_q + 1'b1;
    end
  end

  assign wp_count = wp_count_q;
`else
  assign wp_block = 1'b0;
`endif

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    case (owner)
      OWN_FLASH: begin
        ram_addr  = flash_addr;
        ram_wdata = flash_wdata;
        ram_cs    = flash_cs;
        ram_we    = flash_we;
      end
      OWN_CPU: begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_cs    = cpu_cs;
        ram_we    = cpu_we & ~wp_block;
      end
      OWN_DIAG: begin
        ram_addr  = diag_addr;
        ram_wdata = diag_wdata;
        ram_cs    = diag_cs;
        ram_we    = diag_we;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset, boot_done;
  logic [15:0] flash_addr, cpu_addr, diag_addr, ram_addr;
  logic [7:0]  flash_wdata, cpu_wdata, diag_wdata, ram_wdata;
  logic        flash_cs, flash_we, cpu_cs, cpu_we, diag_cs, diag_we;
  logic        phi2, rwbar, diag_halt_req;
  logic        ram_cs, ram_we, cpu_rdy, diag_halted, bus_drive_en, drain_timeout;
`ifdef SRAM_ARB_WRITE_PROTECT_EN
  logic [15:0] wp_mask;
  logic [7:0]  wp_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(16), .DATA_W(8), .TO_W(4)) dut (
    .clk(clk), .reset(reset), .boot_done(boot_done),
    .flash_addr(flash_addr), .flash_wdata(flash_wdata), .flash_cs(flash_cs), .flash_we(flash_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
    .phi2(phi2), .rwbar(rwbar), .diag_halt_req(diag_halt_req),
    .diag_addr(diag_addr), .diag_wdata(diag_wdata), .diag_cs(diag_cs), .diag_we(diag_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_cs(ram_cs), .ram_we(ram_we),
    .cpu_rdy(cpu_rdy), .diag_halted(diag_halted), .bus_drive_en(bus_drive_en),
    .drain_timeout(drain_timeout)
`ifdef SRAM_ARB_WRITE_PROTECT_EN
    ,.wp_mask(wp_mask), .wp_count(wp_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; boot_done = 1'b0;
    flash_addr = '0; flash_wdata = '0; flash_cs = 1'b0; flash_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_cs = 1'b0; cpu_we = 1'b0;
    diag_addr = '0; diag_wdata = '0; diag_cs = 1'b0; diag_we = 1'b0;
    phi2 = 1'b1; rwbar = 1'b1; diag_halt_req = 1'b0;
`ifdef SRAM_ARB_WRITE_PROTECT_EN
    wp_mask = 16'h8000;
`endif
    step(); step();
    check("rst_rdy", cpu_rdy, 0);
    check("rst_halted", diag_halted, 0);
    check("rst_drive", bus_drive_en, 0);
    check("rst_to", drain_timeout, 0);
    check("rst_cs", ram_cs, 0);

    // BOOT: flash owns the RAM
    reset = 1'b1;
    flash_addr = 16'h1234; flash_wdata = 8'hA5; flash_cs = 1'b1; flash_we = 1'b1;
    #1;
    check("boot_addr", ram_addr, 16'h1234);
    check("boot_wdata", ram_wdata, 8'hA5);
    check("boot_we", ram_we, 1);
    check("boot_rdy", cpu_rdy, 0);
    step();
    boot_done = 1'b1;
    cpu_addr = 16'h0200; cpu_wdata = 8'h3C; cpu_cs = 1'b1;
    #1;
    check("boot_rdy_pre", cpu_rdy, 0);
    step();
    check("run_rdy", cpu_rdy, 1);
    check("run_drive", bus_drive_en, 1);
    check("run_addr", ram_addr, 16'h0200);
    flash_addr = '0; flash_wdata = '0; flash_cs = 1'b0; flash_we = 1'b0;

    // DRAIN through a write cycle, halt on the following read cycle
    diag_halt_req = 1'b1; rwbar = 1'b0;
    step();
    check("drain_rdy", cpu_rdy, 0);
    check("drain_owner", ram_addr, 16'h0200);
    phi2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("drain_wr_hold", diag_halted, 0);
    end
    phi2 = 1'b1; rwbar = 1'b1;
    step(); step();
    phi2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("drain_rd_wait", diag_halted, 0);
    end
    check("drain_no_to", drain_timeout, 0);
    step();
    check("halt_flag", diag_halted, 1);
    check("halt_rdy", cpu_rdy, 0);
    check("halt_drive", bus_drive_en, 0);
    diag_addr = 16'h4321; diag_wdata = 8'h5A; diag_cs = 1'b1; diag_we = 1'b1;
    #1;
    check("halt_addr", ram_addr, 16'h4321);
    check("halt_we", ram_we, 1);

    // Release: one RESUME clock with no owner
    diag_halt_req = 1'b0;
    step();
    check("resume_cs", ram_cs, 0);
    check("resume_addr", ram_addr, 0);
    check("resume_rdy", cpu_rdy, 0);
    check("resume_halted", diag_halted, 0);
    step();
    check("rerun_rdy", cpu_rdy, 1);
    check("rerun_addr", ram_addr, 16'h0200);
    check("rerun_cs", ram_cs, 1);

    // Timeout with phi2 static
    diag_halt_req = 1'b1;
    step();
    check("to_start", drain_timeout, 0);
    for (int k = 1; k < 15; k++) begin
      step();
      check("to_early", drain_timeout, 0);
    end
    step();
    check("to_pulse", drain_timeout, 1);
    check("to_not_halted", diag_halted, 0);
    step();
    check("to_halted", diag_halted, 1);
    check("to_pulse_end", drain_timeout, 0);

    // Loss of boot_done while HALTED
    boot_done = 1'b0;
    flash_addr = 16'hBEEF; flash_cs = 1'b1;
    step();
    check("reboot_halted", diag_halted, 0);
    check("reboot_rdy", cpu_rdy, 0);
    check("reboot_addr", ram_addr, 16'hBEEF);
    flash_addr = '0; flash_cs = 1'b0;

    // Reset mid-DRAIN
    boot_done = 1'b1;
    step();
    step();
    check("pre_rst_state", dut.state_q, ST_DRAIN);
    reset = 1'b0;
    step();
    check("mid_rst_state", dut.state_q, ST_BOOT);
    check("mid_rst_rdy", cpu_rdy, 0);
    check("mid_rst_halted", diag_halted, 0);
    check("mid_rst_drive", bus_drive_en, 0);
    check("mid_rst_to", drain_timeout, 0);
    check("mid_rst_cs", ram_cs, 0);

    // diag_halt_req dropped during DRAIN returns to RUN
    reset = 1'b1; diag_halt_req = 1'b0;
    step();
    diag_halt_req = 1'b1;
    step();
    check("abort_drain_rdy", cpu_rdy, 0);
    diag_halt_req = 1'b0;
    step();
    check("abort_run_rdy", cpu_rdy, 1);

    // CPU writes to the top page
`ifdef SRAM_ARB_WRITE_PROTECT_EN
    for (int n = 0; n < 3; n++) begin
      cpu_addr = 16'hF000; cpu_cs = 1'b1; cpu_we = 1'b1;
      #1;
      check("wp_we", ram_we, 0);
      step();
      cpu_cs = 1'b0; cpu_we = 1'b0;
      step();
    end
    check("wp_count", wp_count, 3);
    cpu_addr = 16'h7000; cpu_cs = 1'b1; cpu_we = 1'b1;
    #1;
    check("wp_pass", ram_we, 1);
`else
    cpu_addr = 16'hF000; cpu_cs = 1'b1; cpu_we = 1'b1;
    #1;
    check("cpu_we_pass", ram_we, 1);
`endif
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
